// File: rtl/axi4_lite_mem_responder_if.sv
// AXI4-Lite bus bundle between a requester (master) and axi4_lite_mem_responder (slave).
// Signal names keep the responder-side _i/_o suffixes of the original flat port list.
interface axi4_lite_mem_responder_if;
  logic [27:0] awaddr_i;
  logic [2:0]  awprot_i;
  logic        awvalid_i;
  logic        awready_o;
  logic [63:0] wdata_i;
  logic [7:0]  wstrb_i;
  logic        wvalid_i;
  logic        wready_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready_i;
  logic [27:0] araddr_i;
  logic [2:0]  arprot_i;
  logic        arvalid_i;
  logic        arready_o;
  logic [63:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rvalid_o;
  logic        rready_i;

  modport slave (
    input  awaddr_i, awprot_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
    input  araddr_i, arprot_i, arvalid_i, rready_i,
    output awready_o, wready_o, bresp_o, bvalid_o,
    output arready_o, rdata_o, rresp_o, rvalid_o
  );

  modport master (
    output awaddr_i, awprot_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
    output araddr_i, arprot_i, arvalid_i, rready_i,
    input  awready_o, wready_o, bresp_o, bvalid_o,
    input  arready_o, rdata_o, rresp_o, rvalid_o
  );
endinterface

// File: rtl/axi4_lite_mem_responder.sv
// AXI4-Lite subordinate backed by depth_p x 64-bit words; out-of-range accesses get SLVERR.
// Optional AXI4_LITE_MEM_RESPONDER_ALIGN_CHECK_EN: misaligned AW/AR also get SLVERR.
module axi4_lite_mem_responder #(
  parameter int unsigned depth_p = 512
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  axi4_lite_mem_responder_if.slave      s_axi
);

  localparam int unsigned idx_w_lp       = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam logic [1:0]  resp_okay_lp   = 2'b00;
  localparam logic [1:0]  resp_slverr_lp = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;

  w_state_e    w_state_r, w_state_n;
  logic [63:0] mem [depth_p];

  logic        rdy_en_r;
  logic        aw_v_r, w_v_r, bvalid_r;
  logic [27:0] awaddr_r;
  logic [63:0] wdata_r;
  logic [7:0]  wstrb_r;
  logic [1:0]  bresp_r;
  logic        rvalid_r;
  logic [63:0] rdata_r;
  logic [1:0]  rresp_r;

  logic        aw_hs, w_hs, ar_hs, wr_commit, wr_ok, rd_ok;
  logic [27:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic        unused_bits;

  function automatic logic addr_ok(input logic [27:0] a);
    logic ok;
    ok = ({1'b0, a[27:3]} < 26'(depth_p));
`ifdef AXI4_LITE_MEM_RESPONDER_ALIGN_CHECK_EN
    ok = ok & (a[2:0] == 3'b000);
`endif
    return ok;
  endfunction

  function automatic logic [idx_w_lp-1:0] word_idx(input logic [27:0] a);
    return a[3 +: idx_w_lp];
  endfunction

  // The write holds and the pending response are decodes of the FSM state.
  assign aw_v_r   = (w_state_r == W_HAVE_AW);
  assign w_v_r    = (w_state_r == W_HAVE_W);
  assign bvalid_r = (w_state_r == W_RESP);

  assign s_axi.awready_o = rdy_en_r & ~aw_v_r & ~bvalid_r;
  assign s_axi.wready_o  = rdy_en_r & ~w_v_r & ~bvalid_r;
  assign s_axi.bvalid_o  = bvalid_r;
  assign s_axi.bresp_o   = bresp_r;
  assign s_axi.arready_o = rdy_en_r & ~rvalid_r;
  assign s_axi.rvalid_o  = rvalid_r;
  assign s_axi.rdata_o   = rdata_r;
  assign s_axi.rresp_o   = rresp_r;

  assign aw_hs = s_axi.awvalid_i & s_axi.awready_o;
  assign w_hs  = s_axi.wvalid_i & s_axi.wready_o;
  assign ar_hs = s_axi.arvalid_i & s_axi.arready_o;

  assign unused_bits = ^{s_axi.awprot_i, s_axi.arprot_i, wr_addr[2:0], s_axi.araddr_i[2:0]};

  always_comb begin
    w_state_n = w_state_r;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs && w_hs) w_state_n = W_RESP;
        else if (aw_hs)    w_state_n = W_HAVE_AW;
        else if (w_hs)     w_state_n = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  w_state_n = W_RESP;
      W_HAVE_W:  if (aw_hs) w_state_n = W_RESP;
      W_RESP:    if (s_axi.bready_i) w_state_n = W_IDLE;
      default:   w_state_n = W_IDLE;
    endcase
  end

  // A write commits on the edge that moves the FSM into W_RESP; the held
  // channel comes from the capture registers, the other straight from the bus.
  always_comb begin
    wr_commit = (w_state_n == W_RESP) && !bvalid_r;
    wr_addr   = aw_v_r ? awaddr_r : s_axi.awaddr_i;
    wr_data   = w_v_r ? wdata_r : s_axi.wdata_i;
    wr_strb   = w_v_r ? wstrb_r : s_axi.wstrb_i;
    wr_ok     = addr_ok(wr_addr);
    rd_ok     = addr_ok(s_axi.araddr_i);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_state_r <= W_IDLE;
      rdy_en_r  <= 1'b0;
      awaddr_r  <= '0;
      wdata_r   <= '0;
      wstrb_r   <= '0;
      bresp_r   <= resp_okay_lp;
    end else begin
      w_state_r <= w_state_n;
      rdy_en_r  <= 1'b1;
      if (aw_hs) awaddr_r <= s_axi.awaddr_i;
      if (w_hs) begin
        wdata_r <= s_axi.wdata_i;
        wstrb_r <= s_axi.wstrb_i;
      end
      if (wr_commit) bresp_r <= wr_ok ? resp_okay_lp : resp_slverr_lp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_commit && wr_ok) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (wr_strb[b]) mem[word_idx(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Reads sample the array before any same-edge write lands (read-before-write).
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
      rresp_r  <= resp_okay_lp;
    end else if (ar_hs) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rd_ok ? mem[word_idx(s_axi.araddr_i)] : '0;
      rresp_r  <= rd_ok ? resp_okay_lp : resp_slverr_lp;
    end else if (rvalid_r && s_axi.rready_i) begin
      rvalid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_mem_responder.sv
// Scoreboard bench for axi4_lite_mem_responder: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them on each completed handshake.
module tb_axi4_lite_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_lite_mem_responder_if bus();

  axi4_lite_mem_responder #(.depth_p(512)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .s_axi     (bus.slave)
  );

  typedef struct {
    logic [63:0] d;
    logic [1:0]  r;
  } rexp_t;

  logic [1:0] bq[$];
  rexp_t      rq[$];
  int total = 0;
  int bad   = 0;

`ifdef AXI4_LITE_MEM_RESPONDER_ALIGN_CHECK_EN
  localparam bit align_en = 1'b1;
`else
  localparam bit align_en = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return bus.awready_o && bus.wready_o;
      1:       return bus.awready_o;
      2:       return bus.wready_o;
      3:       return bus.arready_o;
      default: return bus.awready_o && bus.wready_o && bus.arready_o;
    endcase
  endfunction

  task automatic wait_ready(input string nm, input int sel);
    int n = 0;
    @(negedge clk);
    while (!rdy(sel)) begin
      if (n == 50) begin
        total++;
        bad++;
        $display("FAIL %s: got timeout want ready", nm);
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic write_both(input logic [27:0] a, input logic [63:0] d,
                            input logic [7:0] s, input logic [1:0] er);
    bq.push_back(er);
    @(posedge clk); #1;
    bus.awaddr_i = a; bus.wdata_i = d; bus.wstrb_i = s;
    bus.awvalid_i = 1'b1; bus.wvalid_i = 1'b1;
    wait_ready("aw_w_ready", 0);
    @(posedge clk); #1;
    bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
    @(negedge clk);
    chk("b_latency", bus.bvalid_o, 1);
  endtask

  task automatic read(input logic [27:0] a, input logic [63:0] ed, input logic [1:0] er);
    rq.push_back('{ed, er});
    @(posedge clk); #1;
    bus.araddr_i = a; bus.arvalid_i = 1'b1;
    wait_ready("ar_ready", 3);
    @(posedge clk); #1;
    bus.arvalid_i = 1'b0;
    @(negedge clk);
    chk("r_latency", bus.rvalid_o, 1);
  endtask

  // Monitor: compares every completed B/R handshake against the scoreboard.
  initial begin
    logic [1:0] be;
    rexp_t      re;
    forever begin
      @(negedge clk);
      if (rst_n && bus.bvalid_o && bus.bready_i) begin
        if (bq.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected: got bresp %b want no response", bus.bresp_o);
        end else begin
          be = bq.pop_front();
          chk("bresp", bus.bresp_o, be);
        end
      end
      if (rst_n && bus.rvalid_o && bus.rready_i) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL r_unexpected: got rdata %h want no response", bus.rdata_o);
        end else begin
          re = rq.pop_front();
          chk("rdata", bus.rdata_o, re.d);
          chk("rresp", bus.rresp_o, re.r);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.awaddr_i = '0; bus.awprot_i = '0; bus.awvalid_i = 1'b0;
    bus.wdata_i = '0; bus.wstrb_i = '0; bus.wvalid_i = 1'b0;
    bus.bready_i = 1'b1;
    bus.araddr_i = '0; bus.arprot_i = '0; bus.arvalid_i = 1'b0;
    bus.rready_i = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_awready", bus.awready_o, 0);
    chk("rst_wready", bus.wready_o, 0);
    chk("rst_arready", bus.arready_o, 0);
    chk("rst_bvalid", bus.bvalid_o, 0);
    chk("rst_rvalid", bus.rvalid_o, 0);
    chk("rst_bresp", bus.bresp_o, 0);
    chk("rst_rresp", bus.rresp_o, 0);
    chk("rst_rdata", bus.rdata_o, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_before_edge", bus.awready_o, 0);
    @(negedge clk);
    chk("rdy_after_edge_aw", bus.awready_o, 1);
    chk("rdy_after_edge_ar", bus.arready_o, 1);

    // Basic same-cycle write and readback
    write_both(28'h0000010, 64'hDEADBEEF_01234567, 8'hFF, 2'b00);
    read(28'h0000010, 64'hDEADBEEF_01234567, 2'b00);

    // W three cycles ahead of AW, partial strobe over all-ones
    write_both(28'h0000008, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 2'b00);
    bq.push_back(2'b00);
    @(posedge clk); #1;
    bus.wdata_i = 64'h0; bus.wstrb_i = 8'h0F; bus.wvalid_i = 1'b1;
    wait_ready("w_ready", 2);
    @(posedge clk); #1;
    bus.wvalid_i = 1'b0;
    @(negedge clk);
    chk("wready_held", bus.wready_o, 0);
    chk("awready_idle", bus.awready_o, 1);
    chk("no_b_yet", bus.bvalid_o, 0);
    repeat (2) @(posedge clk);
    #1;
    bus.awaddr_i = 28'h0000008; bus.awvalid_i = 1'b1;
    wait_ready("aw_ready", 1);
    @(posedge clk); #1;
    bus.awvalid_i = 1'b0;
    @(negedge clk);
    chk("b_after_aw", bus.bvalid_o, 1);
    read(28'h0000008, 64'hFFFFFFFF_00000000, 2'b00);

    // Strobe of zero commits nothing
    write_both(28'h0000008, 64'h12345678_12345678, 8'h00, 2'b00);
    read(28'h0000008, 64'hFFFFFFFF_00000000, 2'b00);

    // Out of range: index 512 must not alias word 0
    write_both(28'h0000000, 64'h00000000_CAFEF00D, 8'hFF, 2'b00);
    write_both(28'h0000FF8, 64'h77777777_77777777, 8'hFF, 2'b00);
    write_both(28'h0001000, 64'hBADBADBA_DBADBADB, 8'hFF, 2'b10);
    read(28'h0000FF8, 64'h77777777_77777777, 2'b00);
    read(28'h0001000, 64'h0, 2'b10);
    read(28'h0000000, 64'h00000000_CAFEF00D, 2'b00);
    read(28'hFFFFFF8, 64'h0, 2'b10);

    // Back-pressure on B
    bus.bready_i = 1'b0;
    write_both(28'h0000018, 64'h01234567_89ABCDEF, 8'hFF, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bstall_bvalid", bus.bvalid_o, 1);
      chk("bstall_bresp", bus.bresp_o, 0);
      chk("bstall_awready", bus.awready_o, 0);
      chk("bstall_wready", bus.wready_o, 0);
    end
    @(posedge clk); #1; bus.bready_i = 1'b1;
    @(negedge clk);

    // Back-pressure on R
    bus.rready_i = 1'b0;
    read(28'h0000018, 64'h01234567_89ABCDEF, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rstall_rvalid", bus.rvalid_o, 1);
      chk("rstall_rdata", bus.rdata_o, 64'h01234567_89ABCDEF);
      chk("rstall_rresp", bus.rresp_o, 0);
      chk("rstall_arready", bus.arready_o, 0);
    end
    @(posedge clk); #1; bus.rready_i = 1'b1;
    @(negedge clk);

    // Same-edge commit and read of word 4: read sees old data
    write_both(28'h0000020, 64'h5, 8'hFF, 2'b00);
    bq.push_back(2'b00);
    rq.push_back('{64'h5, 2'b00});
    @(posedge clk); #1;
    bus.awaddr_i = 28'h0000020; bus.wdata_i = 64'h1; bus.wstrb_i = 8'hFF;
    bus.araddr_i = 28'h0000020;
    bus.awvalid_i = 1'b1; bus.wvalid_i = 1'b1; bus.arvalid_i = 1'b1;
    wait_ready("all_ready", 4);
    @(posedge clk); #1;
    bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0; bus.arvalid_i = 1'b0;
    @(negedge clk);
    chk("rbw_bvalid", bus.bvalid_o, 1);
    chk("rbw_rvalid", bus.rvalid_o, 1);
    read(28'h0000020, 64'h1, 2'b00);

    // Misaligned accesses
    write_both(28'h0000028, 64'h55555555_55555555, 8'hFF, 2'b00);
    read(28'h0000004, align_en ? 64'h0 : 64'h00000000_CAFEF00D, align_en ? 2'b10 : 2'b00);
    write_both(28'h000002C, 64'h99999999_99999999, 8'hFF, align_en ? 2'b10 : 2'b00);
    read(28'h0000028, align_en ? 64'h55555555_55555555 : 64'h99999999_99999999, 2'b00);

    // Reset while a response is pending; committed data survives
    bus.bready_i = 1'b0;
    write_both(28'h0000030, 64'h30303030_30303030, 8'hFF, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_bvalid", bus.bvalid_o, 0);
    chk("rstmid_rvalid", bus.rvalid_o, 0);
    chk("rstmid_awready", bus.awready_o, 0);
    chk("rstmid_arready", bus.arready_o, 0);
    bq.delete();
    bus.bready_i = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rdy_low", bus.wready_o, 0);
    @(negedge clk);
    chk("rel_awready", bus.awready_o, 1);
    chk("rel_wready", bus.wready_o, 1);
    chk("rel_arready", bus.arready_o, 1);
    read(28'h0000030, 64'h30303030_30303030, 2'b00);
    read(28'h0000010, 64'hDEADBEEF_01234567, 2'b00);

    repeat (3) @(negedge clk);
    chk("b_queue_empty", 64'(bq.size()), 0);
    chk("r_queue_empty", 64'(rq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
